load_store_unit: RTL and testbench

Sequencer between the execute stage and `mem_mgr`'s data read and write ports. It accepts one load or store request at a time and returns one response per request. Aligned accesses go to memory as a single operation. With `LSU_SPLIT_MISALIGNED_EN` defined, misaligned accesses are split into single-byte operations; without it, they are faulted.

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/load_store_unit_load_extend.sv | 34 +++
 rtl/load_store_unit.sv | 202 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types, access-size codes and the alignment helper for the load/store sequencer.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCESS    = 3'd1,
    SPLIT     = 3'd2,
    LOAD_DATA = 3'd3,
    RESP      = 3'd4
  } lsu_state_t;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;
  localparam logic [2:0] SIZE_Q = 3'd4;

  // Only the low four address bits matter for sizes up to 16 bytes.
  function automatic logic is_misaligned(input logic [3:0] addr_lo, input logic [2:0] size);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = |addr_lo[1:0];
      SIZE_D:  mis = |addr_lo[2:0];
      SIZE_Q:  mis = |addr_lo[3:0];
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Sign or zero extension of the low 2^size bytes of a value to the full data width.
module load_extend #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       size,
  input  logic             is_unsigned,
  output logic [WIDTH-1:0] result
);

  int   nbits_s;
  logic sign_s;

  // Locate the top bit of the access and fill everything above it.
  always_comb begin
    case (size)
      3'd0:    nbits_s = 32'sd8;
      3'd1:    nbits_s = 32'sd16;
      3'd2:    nbits_s = 32'sd32;
      3'd3:    nbits_s = 32'sd64;
      3'd4:    nbits_s = 32'sd128;
      default: nbits_s = 32'sd128;
    endcase
    sign_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sign_s = sign_s | ((i == nbits_s - 32'sd1) & value[i]);
    end
    sign_s = sign_s & ~is_unsigned;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = (i < nbits_s) ? value[i] : sign_s;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// One-at-a-time load/store sequencer in front of mem_mgr's read and write ports.
// Define LSU_SPLIT_MISALIGNED_EN to split misaligned accesses into byte operations instead of faulting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [2:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_fault,
  output logic [WIDTH-1:0] mem_wr_addr,
  output logic             mem_we,
  output logic [2:0]       mem_wr_bytes,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic             mem_wr_misaligned,
  output logic [WIDTH-1:0] mem_rd_addr,
  output logic             mem_re,
  output logic [2:0]       mem_rd_bytes,
  output logic             mem_rd_unsigned,
  input  logic [WIDTH-1:0] mem_rd_data,
  input  logic             mem_rd_misaligned
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(BYTES));
`ifdef LSU_SPLIT_MISALIGNED_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  lsu_state_t       state_r, next_state_s;
  logic             store_r, unsigned_r, fault_r;
  logic [2:0]       size_r;
  logic [WIDTH-1:0] addr_r, wdata_r, data_r;
  logic             accept_s, size_bad_s, mis_s, mem_fault_s;
  logic [WIDTH-1:0] ext_in_s, ext_out_s;

  assign accept_s    = req_valid & req_ready;
  assign size_bad_s  = req_size > MAX_SIZE;
  assign mis_s       = is_misaligned(req_addr[3:0], req_size);
  assign mem_fault_s = (mem_we & mem_wr_misaligned) | (mem_re & mem_rd_misaligned);

`ifdef LSU_SPLIT_MISALIGNED_EN
  logic             split_r;
  logic [4:0]       k_r;
  logic [4:0]       last_k_s;
  logic [WIDTH-1:0] asm_r, asm_full_s;

  assign last_k_s = (5'd1 << size_r) - 5'd1;
  assign ext_in_s = split_r ? asm_full_s : mem_rd_data;

  // Merge the byte returned for operation k-1 into the assembly word.
  always_comb begin
    asm_full_s = asm_r;
    for (int b = 0; b < BYTES; b++) begin
      if (5'(b) == k_r - 5'd1) asm_full_s[b*8 +: 8] = mem_rd_data[7:0];
      else                     asm_full_s[b*8 +: 8] = asm_r[b*8 +: 8];
    end
  end
`else
  assign ext_in_s = mem_rd_data;
`endif

  // Memory already extends aligned loads; re-extending with the same size is a no-op.
  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .value       (ext_in_s),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .result      (ext_out_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                     next_state_s = IDLE;
        else if (size_bad_s)               next_state_s = RESP;
        else if (mis_s && SPLIT_EN)        next_state_s = SPLIT;
        else if (mis_s)                    next_state_s = RESP;
        else                               next_state_s = ACCESS;
      end
      ACCESS:    next_state_s = store_r ? RESP : LOAD_DATA;
`ifdef LSU_SPLIT_MISALIGNED_EN
      SPLIT: begin
        if (k_r == last_k_s) next_state_s = store_r ? RESP : LOAD_DATA;
        else                 next_state_s = SPLIT;
      end
`endif
      LOAD_DATA: next_state_s = RESP;
      RESP:      next_state_s = IDLE;
      default:   next_state_s = IDLE;
    endcase
  end

  // Request capture, fault tracking and load data assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_r    <= 1'b0;
      unsigned_r <= 1'b0;
      fault_r    <= 1'b0;
      size_r     <= 3'd0;
      addr_r     <= '0;
      wdata_r    <= '0;
      data_r     <= '0;
`ifdef LSU_SPLIT_MISALIGNED_EN
      split_r    <= 1'b0;
      k_r        <= 5'd0;
      asm_r      <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            store_r    <= req_store;
            unsigned_r <= req_unsigned;
            size_r     <= req_size;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
            data_r     <= '0;
            fault_r    <= size_bad_s | (mis_s & ~SPLIT_EN);
`ifdef LSU_SPLIT_MISALIGNED_EN
            split_r    <= mis_s & ~size_bad_s;
            k_r        <= 5'd0;
            asm_r      <= '0;
`endif
          end
        end
        ACCESS: begin
          if (mem_fault_s) fault_r <= 1'b1;
        end
`ifdef LSU_SPLIT_MISALIGNED_EN
        SPLIT: begin
          k_r <= k_r + 5'd1;
          if (mem_fault_s) fault_r <= 1'b1;
          if (!store_r)    asm_r   <= asm_full_s;
        end
`endif
        LOAD_DATA: data_r <= fault_r ? '0 : ext_out_s;
        default: ;
      endcase
    end
  end

  // Port outputs decoded from the registered state; reset silences every strobe at once.
  always_comb begin
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_fault      = 1'b0;
    resp_data       = '0;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    mem_wr_addr     = addr_r;
    mem_wr_bytes    = size_r;
    mem_wr_data     = wdata_r;
    mem_rd_addr     = addr_r;
    mem_rd_bytes    = size_r;
    mem_rd_unsigned = unsigned_r;
    case (state_r)
      IDLE: req_ready = ~rst;
      ACCESS: begin
        mem_we = store_r & ~rst;
        mem_re = ~store_r & ~rst;
      end
`ifdef LSU_SPLIT_MISALIGNED_EN
      SPLIT: begin
        mem_we          = store_r & ~rst;
        mem_re          = ~store_r & ~rst;
        mem_wr_addr     = addr_r + WIDTH'(k_r);
        mem_rd_addr     = addr_r + WIDTH'(k_r);
        mem_wr_bytes    = SIZE_B;
        mem_rd_bytes    = SIZE_B;
        mem_wr_data     = wdata_r >> {k_r, 3'b000};
        mem_rd_unsigned = 1'b1;
      end
`endif
      RESP: begin
        resp_valid = ~rst;
        resp_fault = fault_r & ~rst;
        resp_data  = (fault_r | rst) ? '0 : data_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array model of mem_mgr's ports.
// Expectations follow LSU_SPLIT_MISALIGNED_EN when it is defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_data;
  logic [31:0] mem_wr_addr, mem_wr_data, mem_rd_addr, mem_rd_data;
  logic        mem_we, mem_re, mem_rd_unsigned, mem_wr_misaligned, mem_rd_misaligned;
  logic [2:0]  mem_wr_bytes, mem_rd_bytes;

  logic [7:0]  mem_b [0:511];
  logic [31:0] rd_q;
  logic        force_mis = 1'b0;
  int          overlap = 0;
  int          tests = 0;
  int          fails = 0;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .mem_wr_addr(mem_wr_addr), .mem_we(mem_we), .mem_wr_bytes(mem_wr_bytes),
    .mem_wr_data(mem_wr_data), .mem_wr_misaligned(mem_wr_misaligned),
    .mem_rd_addr(mem_rd_addr), .mem_re(mem_re), .mem_rd_bytes(mem_rd_bytes),
    .mem_rd_unsigned(mem_rd_unsigned), .mem_rd_data(mem_rd_data),
    .mem_rd_misaligned(mem_rd_misaligned)
  );

  always #5 clk = ~clk;

  assign mem_rd_data       = rd_q;
  assign mem_wr_misaligned = force_mis | (mem_we & (|(mem_wr_addr & ((32'd1 << mem_wr_bytes) - 32'd1))));
  assign mem_rd_misaligned = force_mis | (mem_re & (|(mem_rd_addr & ((32'd1 << mem_rd_bytes) - 32'd1))));

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] b, input logic u);
    logic [31:0] r;
    int n;
    r = 32'd0;
    n = 1 << b;
    if (n > 4) n = 4;
    for (int i = 0; i < 4; i++)
      if (i < n) r[8*i +: 8] = mem_b[9'(a + 32'(i))];
    if (!u && n < 4)
      for (int i = 0; i < 32; i++)
        if (i >= 8*n) r[i] = r[8*n-1];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (i < (1 << mem_wr_bytes)) mem_b[9'(mem_wr_addr + 32'(i))] <= mem_wr_data[8*i +: 8];
    if (mem_re) rd_q <= mem_read(mem_rd_addr, mem_rd_bytes, mem_rd_unsigned);
    if (mem_we && mem_re) overlap <= overlap + 1;
  end

  typedef struct {
    logic        store;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        fmis;
    int          exp_cyc;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          exp_we;
    int          exp_re;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] wr_addrs[$];
  logic [31:0] wr_datas[$];
  int          wr_cycs[$];

  function automatic vec_t mk(input logic st, input logic [31:0] a, input logic [2:0] sz,
                              input logic u, input logic [31:0] wd, input logic fm, input int cyc,
                              input logic [31:0] d, input logic f, input int nwe, input int nre);
    vec_t v;
    v.store = st; v.addr = a; v.size = sz; v.uns = u; v.wdata = wd; v.fmis = fm;
    v.exp_cyc = cyc; v.exp_data = d; v.exp_fault = f; v.exp_we = nwe; v.exp_re = nre;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_store = v.store; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata; req_valid = 1'b1;
  endtask

  // Issues one request, treats the negedge before the accepting posedge as cycle 0.
  task automatic run_req(input vec_t v, output int rc, output logic [31:0] rd,
                         output logic rf, output int nwe, output int nre);
    int t;
    @(negedge clk);
    drive_req(v);
    force_mis = v.fmis;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    rc = -1; rd = 32'd0; rf = 1'b0; nwe = 0; nre = 0;
    wr_addrs.delete(); wr_datas.delete(); wr_cycs.delete();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin
        nwe++;
        wr_addrs.push_back(mem_wr_addr);
        wr_datas.push_back(mem_wr_data);
        wr_cycs.push_back(c);
      end
      if (mem_re) nre++;
      if (resp_valid) begin
        rc = c; rd = resp_data; rf = resp_fault;
        break;
      end
    end
    force_mis = 1'b0;
  endtask

  initial begin
    int          rc, nwe, nre, bad, n_exp;
    logic [31:0] rd, base;
    logic        rf;
    vec_t        v;

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = 32'd0;
    req_size = 3'd0; req_unsigned = 1'b0; req_wdata = 32'd0;

    vecs.push_back(mk(1'b1, 32'h100, 3'd2, 1'b0, 32'hDEADBEEF, 1'b0, 2, 32'h0,        1'b0, 1, 0));
    vecs.push_back(mk(1'b0, 32'h100, 3'd2, 1'b0, 32'h0,        1'b0, 3, 32'hDEADBEEF, 1'b0, 0, 1));
    vecs.push_back(mk(1'b1, 32'h103, 3'd0, 1'b0, 32'h80,       1'b0, 2, 32'h0,        1'b0, 1, 0));
    vecs.push_back(mk(1'b0, 32'h103, 3'd0, 1'b0, 32'h0,        1'b0, 3, 32'hFFFFFF80, 1'b0, 0, 1));
    vecs.push_back(mk(1'b0, 32'h103, 3'd0, 1'b1, 32'h0,        1'b0, 3, 32'h00000080, 1'b0, 0, 1));
    vecs.push_back(mk(1'b0, 32'h102, 3'd1, 1'b0, 32'h0,        1'b0, 3, 32'hFFFF80AD, 1'b0, 0, 1));
    vecs.push_back(mk(1'b0, 32'h102, 3'd1, 1'b1, 32'h0,        1'b0, 3, 32'h000080AD, 1'b0, 0, 1));
    vecs.push_back(mk(1'b0, 32'h100, 3'd3, 1'b0, 32'h0,        1'b0, 1, 32'h0,        1'b1, 0, 0));
    vecs.push_back(mk(1'b1, 32'h100, 3'd4, 1'b0, 32'h12345678, 1'b0, 1, 32'h0,        1'b1, 0, 0));
    vecs.push_back(mk(1'b0, 32'h100, 3'd2, 1'b0, 32'h0,        1'b1, 3, 32'h0,        1'b1, 0, 1));
    vecs.push_back(mk(1'b1, 32'h104, 3'd2, 1'b0, 32'h01020304, 1'b1, 2, 32'h0,        1'b1, 1, 0));
`ifdef LSU_SPLIT_MISALIGNED_EN
    vecs.push_back(mk(1'b1, 32'h101, 3'd2, 1'b0, 32'h11223344, 1'b0, 5, 32'h0,        1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 32'h103, 3'd1, 1'b0, 32'h0,        1'b0, 4, 32'h00001122, 1'b0, 0, 2));
    vecs.push_back(mk(1'b0, 32'h101, 3'd2, 1'b1, 32'h0,        1'b0, 6, 32'h11223344, 1'b0, 0, 4));
    vecs.push_back(mk(1'b1, 32'h105, 3'd1, 1'b0, 32'h8899,     1'b0, 3, 32'h0,        1'b0, 2, 0));
    vecs.push_back(mk(1'b0, 32'h105, 3'd1, 1'b0, 32'h0,        1'b0, 4, 32'hFFFF8899, 1'b0, 0, 2));
    vecs.push_back(mk(1'b0, 32'h105, 3'd1, 1'b1, 32'h0,        1'b0, 4, 32'h00008899, 1'b0, 0, 2));
    vecs.push_back(mk(1'b0, 32'h100, 3'd2, 1'b0, 32'h0,        1'b0, 3, 32'h223344EF, 1'b0, 0, 1));
`else
    vecs.push_back(mk(1'b0, 32'h102, 3'd2, 1'b0, 32'h0,        1'b0, 1, 32'h0,        1'b1, 0, 0));
    vecs.push_back(mk(1'b1, 32'h101, 3'd2, 1'b0, 32'h11223344, 1'b0, 1, 32'h0,        1'b1, 0, 0));
    vecs.push_back(mk(1'b0, 32'h103, 3'd1, 1'b0, 32'h0,        1'b0, 1, 32'h0,        1'b1, 0, 0));
    vecs.push_back(mk(1'b0, 32'h100, 3'd2, 1'b0, 32'h0,        1'b0, 3, 32'h80ADBEEF, 1'b0, 0, 1));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_en", 32'({mem_we, mem_re}), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      run_req(vecs[i], rc, rd, rf, nwe, nre);
      check($sformatf("v%0d_resp_cycle", i), 32'(rc), 32'(vecs[i].exp_cyc));
      check($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
      check($sformatf("v%0d_fault", i), 32'(rf), 32'(vecs[i].exp_fault));
      check($sformatf("v%0d_writes", i), 32'(nwe), 32'(vecs[i].exp_we));
      check($sformatf("v%0d_reads", i), 32'(nre), 32'(vecs[i].exp_re));
    end

    // Write sequencing: addresses, data bytes and cycles of each memory write
`ifdef LSU_SPLIT_MISALIGNED_EN
    base = 32'h0F1; n_exp = 4;
`else
    base = 32'h0F0; n_exp = 1;
`endif
    run_req(mk(1'b1, base, 3'd2, 1'b0, 32'hA1B2C3D4, 1'b0, 0, 32'h0, 1'b0, 0, 0), rc, rd, rf, nwe, nre);
    check("seq_write_count", 32'(wr_addrs.size()), 32'(n_exp));
    check("seq_resp_cycle", 32'(rc), 32'(n_exp + 1));
    for (int i = 0; i < n_exp && i < wr_addrs.size(); i++) begin
      check($sformatf("seq_w%0d_addr", i), wr_addrs[i], base + 32'(i));
      check($sformatf("seq_w%0d_cycle", i), 32'(wr_cycs[i]), 32'(i + 1));
      if (n_exp == 1) check("seq_w_data", wr_datas[i], 32'hA1B2C3D4);
      else            check($sformatf("seq_w%0d_byte", i), 32'(wr_datas[i][7:0]), 32'(8'(32'hA1B2C3D4 >> (8*i))));
    end

    // Reset in cycle 2 of an access aborts it; a held request is accepted right after release
`ifdef LSU_SPLIT_MISALIGNED_EN
    v = mk(1'b1, 32'h101, 3'd2, 1'b0, 32'hAABBCCDD, 1'b0, 0, 32'h0, 1'b0, 0, 0);
`else
    v = mk(1'b0, 32'h100, 3'd2, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 0);
`endif
    @(negedge clk);
    drive_req(v);
    bad = 0;
    while (!req_ready && bad < 50) begin
      @(negedge clk);
      bad++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_c1_enable", 32'({mem_we, mem_re}), v.store ? 32'd2 : 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive_req(mk(1'b0, 32'h100, 3'd2, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 0));
    #1;
    check("abort_c2_quiet", 32'({mem_we, mem_re, resp_valid, req_ready}), 32'd0);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we || mem_re || resp_valid || req_ready) bad++;
    end
    check("abort_rst_quiet", 32'(bad), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_after_rst", 32'(req_ready), 32'd1);
    rc = -1; rd = 32'd0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin
        rc = c; rd = resp_data;
        break;
      end
    end
    check("abort_next_resp_cycle", 32'(rc), 32'd3);
`ifdef LSU_SPLIT_MISALIGNED_EN
    check("abort_next_data", rd, 32'h2233DDEF);
    check("abort_byte1_untouched", 32'(mem_b[9'h102]), 32'h33);
`else
    check("abort_next_data", rd, 32'h80ADBEEF);
`endif

    check("we_re_overlap", 32'(overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
